// File: rtl/vm_change_dispenser_pkg.sv
// Shared definitions for the vending machine change dispenser: state encoding
// and the default coin set / timeout used by vm_change_dispenser.
package vm_change_dispenser_pkg;

  typedef enum logic [1:0] {
    kStIdle   = 2'd0,
    kStHold   = 2'd1,
    kStReturn = 2'd2
  } state_e;

  localparam int unsigned DefNumCoins = 3;
  localparam int unsigned DefBalW     = 16;
  localparam int unsigned DefTimerW   = 32;
  localparam int unsigned DefTimeout  = 100;

  // Packed coin values, index 0 in the low bits, strictly ascending.
  localparam logic [DefNumCoins*DefBalW-1:0] DefCoinValues = {16'd1000, 16'd500, 16'd100};

endpackage

// File: rtl/vm_change_dispenser_if.sv
// Signal bundle between vm_change_dispenser (slave) and the surrounding
// coin front end, dispense FSM and coin-return actuator (master).
interface vm_change_dispenser_if
  import vm_change_dispenser_pkg::*;
#(
  parameter int unsigned NUM_COINS = DefNumCoins,
  parameter int unsigned BAL_W     = DefBalW,
  parameter int unsigned TIMER_W   = DefTimerW
);
  logic                 i_coin_valid;
  logic [NUM_COINS-1:0] i_coin_sel;
  logic                 o_coin_accept;
  logic                 i_activity;
  logic                 i_debit_valid;
  logic [BAL_W-1:0]     i_debit_amt;
  logic                 o_debit_ok;
  logic                 o_debit_fail;
  logic                 i_return_req;
  logic                 o_ret_valid;
  logic [NUM_COINS-1:0] o_ret_coin;
  logic                 i_ret_ready;
  logic [BAL_W-1:0]     o_balance;
  logic [TIMER_W-1:0]   o_wait_time;
  logic                 o_busy;
  logic                 o_residual;

  modport master (
    output i_coin_valid, i_coin_sel, i_activity, i_debit_valid, i_debit_amt,
           i_return_req, i_ret_ready,
    input  o_coin_accept, o_debit_ok, o_debit_fail, o_ret_valid, o_ret_coin,
           o_balance, o_wait_time, o_busy, o_residual
  );

  modport slave (
    input  i_coin_valid, i_coin_sel, i_activity, i_debit_valid, i_debit_amt,
           i_return_req, i_ret_ready,
    output o_coin_accept, o_debit_ok, o_debit_fail, o_ret_valid, o_ret_coin,
           o_balance, o_wait_time, o_busy, o_residual
  );
endinterface

// File: rtl/vm_change_dispenser_coin_picker.sv
// vm_coin_picker: combinational greedy selector returning the largest coin
// whose value fits in the balance, or a none-fits flag.
module vm_coin_picker
  import vm_change_dispenser_pkg::*;
#(
  parameter int unsigned                   NUM_COINS   = DefNumCoins,
  parameter int unsigned                   BAL_W       = DefBalW,
  parameter logic [NUM_COINS*BAL_W-1:0]    COIN_VALUES = DefCoinValues
) (
  input  logic [BAL_W-1:0]     balance_i,
  output logic [NUM_COINS-1:0] coin_o,
  output logic                 none_fits_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    coin_o      = '0;
    none_fits_o = 1'b1;
    // Ascending scan: the last fitting coin is the largest one.
    for (int i = 0; i < NUM_COINS; i++) begin
      if (COIN_VALUES[i*BAL_W +: BAL_W] <= balance_i) begin
        coin_o      = '0;
        coin_o[i]   = 1'b1;
        none_fits_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vm_change_dispenser.sv
// Customer balance keeper with inactivity timeout and greedy change return.
// Timer-driven auto return is compiled only when VM_AUTO_RETURN_EN is defined.
module vm_change_dispenser
  import vm_change_dispenser_pkg::*;
#(
  parameter int unsigned                NUM_COINS   = DefNumCoins,
  parameter int unsigned                BAL_W       = DefBalW,
  parameter int unsigned                TIMER_W     = DefTimerW,
  parameter int unsigned                TIMEOUT     = DefTimeout,
  parameter logic [NUM_COINS*BAL_W-1:0] COIN_VALUES = DefCoinValues
) (
  input  logic                  clk,
  input  logic                  reset,
  vm_change_dispenser_if.slave  bus
);

  state_e               state_q, state_d;
  logic [BAL_W-1:0]     balance_q, balance_d;
  logic                 ret_valid_q, ret_valid_d;
  logic [NUM_COINS-1:0] ret_coin_q, ret_coin_d;
  logic                 coin_accept_q, coin_accept_d;
  logic                 debit_ok_q, debit_ok_d;
  logic                 debit_fail_q, debit_fail_d;
  logic                 residual_q, residual_d;

  logic [BAL_W-1:0]     coin_val, ret_val, debit_sub, net_bal;
  logic [BAL_W:0]       sum_no_coin, sum_w_coin;
  logic                 coin_ok, coin_take, debit_ok, timeout;
  logic [NUM_COINS-1:0] pick_coin;
  logic                 none_fits;

  vm_coin_picker #(
    .NUM_COINS   (NUM_COINS),
    .BAL_W       (BAL_W),
    .COIN_VALUES (COIN_VALUES)
  ) u_picker (
    .balance_i   (balance_q),
    .coin_o      (pick_coin),
    .none_fits_o (none_fits)
  );

  always_comb begin
    coin_val = '0;
    ret_val  = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (bus.i_coin_sel[i]) coin_val |= COIN_VALUES[i*BAL_W +: BAL_W];
      if (ret_coin_q[i])     ret_val  |= COIN_VALUES[i*BAL_W +: BAL_W];
    end
  end

  // Debit is judged on the old balance; overflow is judged on the net result.
  assign coin_ok     = bus.i_coin_valid && $onehot(bus.i_coin_sel) && (state_q != kStReturn);
  assign debit_ok    = bus.i_debit_valid && (state_q == kStHold) && (bus.i_debit_amt <= balance_q);
  assign debit_sub   = debit_ok ? bus.i_debit_amt : '0;
  assign sum_no_coin = {1'b0, balance_q} - {1'b0, debit_sub};
  assign sum_w_coin  = sum_no_coin + {1'b0, coin_val};
  assign coin_take   = coin_ok && !sum_w_coin[BAL_W];
  assign net_bal     = coin_take ? sum_w_coin[BAL_W-1:0] : sum_no_coin[BAL_W-1:0];

  always_comb begin
    state_d       = state_q;
    balance_d     = balance_q;
    ret_valid_d   = ret_valid_q;
    ret_coin_d    = ret_coin_q;
    coin_accept_d = 1'b0;
    debit_ok_d    = debit_ok;
    debit_fail_d  = bus.i_debit_valid && !debit_ok;
    residual_d    = 1'b0;
    unique case (state_q)
      kStIdle: begin
        coin_accept_d = coin_take;
        balance_d     = net_bal;
        if (coin_take) state_d = kStHold;
      end
      kStHold: begin
        coin_accept_d = coin_take;
        balance_d     = net_bal;
        if (net_bal == '0)                    state_d = kStIdle;
        else if (bus.i_return_req || timeout) state_d = kStReturn;
      end
      kStReturn: begin
        if (ret_valid_q) begin
          if (bus.i_ret_ready) begin
            balance_d   = balance_q - ret_val;
            ret_valid_d = 1'b0;
            ret_coin_d  = '0;
          end
        end else if (none_fits) begin
          balance_d  = '0;
          residual_d = |balance_q;
          state_d    = kStIdle;
        end else begin
          ret_valid_d = 1'b1;
          ret_coin_d  = pick_coin;
        end
      end
      default: state_d = kStIdle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= kStIdle;
      balance_q     <= '0;
      ret_valid_q   <= 1'b0;
      ret_coin_q    <= '0;
      coin_accept_q <= 1'b0;
      debit_ok_q    <= 1'b0;
      debit_fail_q  <= 1'b0;
      residual_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      balance_q     <= balance_d;
      ret_valid_q   <= ret_valid_d;
      ret_coin_q    <= ret_coin_d;
      coin_accept_q <= coin_accept_d;
      debit_ok_q    <= debit_ok_d;
      debit_fail_q  <= debit_fail_d;
      residual_q    <= residual_d;
    end
  end

`ifdef VM_AUTO_RETURN_EN
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               reload;

  assign reload  = coin_take || bus.i_activity || debit_ok;
  assign timeout = (state_q == kStHold) && !reload && (timer_q <= TIMER_W'(1));

  // Timer only runs while the next state is HOLD; it reads 0 elsewhere.
  always_comb begin
    timer_d = '0;
    if (state_d == kStHold) timer_d = reload ? TIMER_W'(TIMEOUT) : timer_q - TIMER_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign bus.o_wait_time = timer_q;
`else
  logic unused_activity;

  assign timeout         = 1'b0;
  assign bus.o_wait_time = '0;
  assign unused_activity = bus.i_activity ^ (TIMEOUT == 0);
`endif

  assign bus.o_coin_accept = coin_accept_q;
  assign bus.o_debit_ok    = debit_ok_q;
  assign bus.o_debit_fail  = debit_fail_q;
  assign bus.o_ret_valid   = ret_valid_q;
  assign bus.o_ret_coin    = ret_coin_q;
  assign bus.o_balance     = balance_q;
  assign bus.o_busy        = (state_q == kStReturn);
  assign bus.o_residual    = residual_q;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser with coins 100/500/1000, TIMEOUT=10.
// Timer expectations adapt to whether VM_AUTO_RETURN_EN is defined.
module tb_vm_change_dispenser;

`ifdef VM_AUTO_RETURN_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif

  localparam logic [2:0] C100  = 3'b001;
  localparam logic [2:0] C500  = 3'b010;
  localparam logic [2:0] C1000 = 3'b100;

  logic clk = 1'b0;
  logic reset;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  vm_change_dispenser_if #(.NUM_COINS(3), .BAL_W(16), .TIMER_W(32)) bus ();

  vm_change_dispenser #(.TIMEOUT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wt(input int v);
    return Auto ? 64'(v) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [2:0] sel, input logic [15:0] bal, input string tag);
    bus.i_coin_valid = 1'b1;
    bus.i_coin_sel   = sel;
    tick();
    bus.i_coin_valid = 1'b0;
    bus.i_coin_sel   = '0;
    check({tag, " accept"}, bus.o_coin_accept, 1);
    check({tag, " bal"}, bus.o_balance, bal);
  endtask

  task automatic debit(input logic [15:0] amt, input logic ok, input logic [15:0] bal, input string tag);
    bus.i_debit_valid = 1'b1;
    bus.i_debit_amt   = amt;
    tick();
    bus.i_debit_valid = 1'b0;
    bus.i_debit_amt   = '0;
    check({tag, " ok"}, bus.o_debit_ok, ok);
    check({tag, " fail"}, bus.o_debit_fail, !ok);
    check({tag, " bal"}, bus.o_balance, bal);
  endtask

  task automatic request_return(input string tag);
    bus.i_return_req = 1'b1;
    tick();
    bus.i_return_req = 1'b0;
    check({tag, " busy"}, bus.o_busy, 1);
  endtask

  // Waits (bounded) for a presented coin, checks it, lets it transfer.
  task automatic collect(input logic [2:0] coin, input logic [15:0] bal_after, input string tag);
    int n = 0;
    while (!bus.o_ret_valid && n < 4) begin
      tick();
      n++;
    end
    check({tag, " valid"}, bus.o_ret_valid, 1);
    check({tag, " coin"}, bus.o_ret_coin, coin);
    tick();
    check({tag, " bal"}, bus.o_balance, bal_after);
    check({tag, " valid drop"}, bus.o_ret_valid, 0);
  endtask

  initial begin
    reset             = 1'b1;
    bus.i_coin_valid  = 1'b0;
    bus.i_coin_sel    = '0;
    bus.i_activity    = 1'b0;
    bus.i_debit_valid = 1'b0;
    bus.i_debit_amt   = '0;
    bus.i_return_req  = 1'b0;
    bus.i_ret_ready   = 1'b0;
    #2;
    check("rst bal", bus.o_balance, 0);
    check("rst wait", bus.o_wait_time, 0);
    check("rst valid", bus.o_ret_valid, 0);
    check("rst coin", bus.o_ret_coin, 0);
    check("rst busy", bus.o_busy, 0);
    check("rst accept", bus.o_coin_accept, 0);
    check("rst residual", bus.o_residual, 0);
    tick();
    tick();
    reset = 1'b0;

    // 1: 500 + 100, then timeout (or explicit return) pays 500, 100.
    bus.i_ret_ready = 1'b1;
    insert(C500, 500, "s1 c500");
    check("s1 wait reload", bus.o_wait_time, wt(10));
    insert(C100, 600, "s1 c100");
    repeat (5) tick();
    check("s1 wait 5", bus.o_wait_time, wt(5));
    repeat (4) tick();
    check("s1 wait 1", bus.o_wait_time, wt(1));
    check("s1 busy pre", bus.o_busy, 0);
    tick();
`ifdef VM_AUTO_RETURN_EN
    check("s1 timeout busy", bus.o_busy, 1);
    check("s1 timeout wait", bus.o_wait_time, 0);
`else
    check("s1 hold busy", bus.o_busy, 0);
    check("s1 hold bal", bus.o_balance, 600);
    request_return("s1 req");
`endif
    collect(C500, 100, "s1 r500");
    collect(C100, 0, "s1 r100");
    tick();
    check("s1 idle busy", bus.o_busy, 0);
    check("s1 residual", bus.o_residual, 0);

    // 2: debits, including exact debit back to IDLE and debit in IDLE.
    insert(C1000, 1000, "s2 c1000");
    insert(C500, 1500, "s2 c500");
    insert(C100, 1600, "s2 c100");
    debit(1500, 1'b1, 100, "s2 d1500");
    check("s2 wait reload", bus.o_wait_time, wt(10));
    debit(200, 1'b0, 100, "s2 d200");
    debit(100, 1'b1, 0, "s2 d100 exact");
    check("s2 exact wait", bus.o_wait_time, 0);
    check("s2 exact busy", bus.o_busy, 0);
    debit(50, 1'b0, 0, "s2 d idle");
    bus.i_coin_valid = 1'b1;
    bus.i_coin_sel   = 3'b011;
    tick();
    bus.i_coin_valid = 1'b0;
    bus.i_coin_sel   = '0;
    check("s2 multi-hot accept", bus.o_coin_accept, 0);
    check("s2 multi-hot bal", bus.o_balance, 0);
    bus.i_return_req = 1'b1;
    tick();
    bus.i_return_req = 1'b0;
    check("s2 idle req busy", bus.o_busy, 0);

    // 3: return with actuator stalled; coin must hold steady.
    insert(C500, 500, "s3 c500");
    bus.i_ret_ready = 1'b0;
    request_return("s3 req");
    tick();
    for (int i = 0; i < 5; i++) begin
      check("s3 stall valid", bus.o_ret_valid, 1);
      check("s3 stall coin", bus.o_ret_coin, C500);
      if (i == 2) begin
        bus.i_coin_valid  = 1'b1;
        bus.i_coin_sel    = C100;
        bus.i_debit_valid = 1'b1;
        bus.i_debit_amt   = 100;
      end
      tick();
      if (i == 2) begin
        bus.i_coin_valid  = 1'b0;
        bus.i_coin_sel    = '0;
        bus.i_debit_valid = 1'b0;
        check("s3 ret coin accept", bus.o_coin_accept, 0);
        check("s3 ret debit fail", bus.o_debit_fail, 1);
        check("s3 ret bal", bus.o_balance, 500);
      end
    end
    bus.i_ret_ready = 1'b1;
    tick();
    check("s3 xfer bal", bus.o_balance, 0);
    check("s3 xfer valid", bus.o_ret_valid, 0);
    tick();
    check("s3 idle busy", bus.o_busy, 0);
    check("s3 residual", bus.o_residual, 0);

    // 4: coin on the last timer cycle reloads instead of timing out.
    insert(C500, 500, "s4 c500");
    insert(C100, 600, "s4 c100");
    repeat (9) tick();
    check("s4 wait 1", bus.o_wait_time, wt(1));
    insert(C100, 700, "s4 c100 late");
    check("s4 reload", bus.o_wait_time, wt(10));
    check("s4 no return", bus.o_busy, 0);
    repeat (3) tick();
    check("s4 wait 7", bus.o_wait_time, wt(7));
    bus.i_activity = 1'b1;
    tick();
    bus.i_activity = 1'b0;
    check("s4 activity reload", bus.o_wait_time, wt(10));
    request_return("s4 req");
    collect(C500, 200, "s4 r500");
    collect(C100, 100, "s4 r100a");
    collect(C100, 0, "s4 r100b");
    tick();
    check("s4 idle busy", bus.o_busy, 0);

    // 5: remainder below smallest coin is discarded with a residual pulse.
    insert(C500, 500, "s5 c500");
    insert(C100, 600, "s5 c100");
    debit(350, 1'b1, 250, "s5 d350");
    request_return("s5 req");
    collect(C100, 150, "s5 r100a");
    collect(C100, 50, "s5 r100b");
    tick();
    check("s5 residual", bus.o_residual, 1);
    check("s5 bal", bus.o_balance, 0);
    check("s5 busy", bus.o_busy, 0);
    tick();
    check("s5 residual drop", bus.o_residual, 0);

    // 7: overflow rejection and net-result check with same-cycle debit.
    for (int i = 1; i <= 65; i++) insert(C1000, 16'(i * 1000), "s7 fill");
    insert(C500, 65500, "s7 c500");
    bus.i_coin_valid = 1'b1;
    bus.i_coin_sel   = C100;
    tick();
    bus.i_coin_valid = 1'b0;
    bus.i_coin_sel   = '0;
    check("s7 ovf accept", bus.o_coin_accept, 0);
    check("s7 ovf bal", bus.o_balance, 65500);
    bus.i_coin_valid  = 1'b1;
    bus.i_coin_sel    = C100;
    bus.i_debit_valid = 1'b1;
    bus.i_debit_amt   = 100;
    tick();
    bus.i_coin_valid  = 1'b0;
    bus.i_coin_sel    = '0;
    bus.i_debit_valid = 1'b0;
    check("s7 net accept", bus.o_coin_accept, 1);
    check("s7 net debit", bus.o_debit_ok, 1);
    check("s7 net bal", bus.o_balance, 65500);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    check("s7 rst bal", bus.o_balance, 0);

    // 6: reset in the middle of paying out 1100.
    tick();
    insert(C1000, 1000, "s6 c1000");
    insert(C100, 1100, "s6 c100");
    request_return("s6 req");
    collect(C1000, 100, "s6 r1000");
    tick();
    check("s6 second valid", bus.o_ret_valid, 1);
    check("s6 second coin", bus.o_ret_coin, C100);
    reset = 1'b1;
    #1;
    check("s6 rst valid", bus.o_ret_valid, 0);
    check("s6 rst coin", bus.o_ret_coin, 0);
    check("s6 rst bal", bus.o_balance, 0);
    check("s6 rst busy", bus.o_busy, 0);
    check("s6 rst wait", bus.o_wait_time, 0);
    tick();
    reset = 1'b0;
    tick();
    check("s6 post busy", bus.o_busy, 0);
    check("s6 post valid", bus.o_ret_valid, 0);
    check("s6 post bal", bus.o_balance, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
